// File: rtl/cpu_core.sv
// Multi-cycle CPU core: FETCH/EXEC/HALT sequencer, 8-entry register file, ALU with Z/N/C/V flags.
// Optional build macro CPU_MUL_EN turns opcode D into MUL; otherwise D is an illegal opcode.
module cpu_core #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              halted,
    output logic              err,
    output logic [3:0]        flags,
    output logic [PC_W-1:0]   dbg_pc
);

    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   r_pc, w_pc_nxt;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_regs [8];
    logic [3:0]        r_flags, w_flags_nxt;
    logic              r_err, w_err_nxt;
    logic              w_load_ir, w_reg_we;

    logic [3:0]        w_op;
    logic [2:0]        w_rd, w_ra, w_rb;
    logic [7:0]        w_imm8;
    logic [PC_W-1:0]   w_tgt;
    logic [DATA_W-1:0] w_a, w_b, w_ldi, w_imm_sx, w_res;
    logic              w_c, w_v, w_writes, w_sets_flags, w_jump, w_stop, w_illegal;

    assign w_op   = r_ir[15:12];
    assign w_rd   = r_ir[11:9];
    assign w_ra   = r_ir[8:6];
    assign w_rb   = r_ir[5:3];
    assign w_imm8 = r_ir[7:0];
    assign w_tgt  = w_imm8[PC_W-1:0];
    assign w_a    = (w_ra == 3'd0) ? '0 : r_regs[w_ra];
    assign w_b    = (w_rb == 3'd0) ? '0 : r_regs[w_rb];

    // imm6 is imm8[5:0]; both extensions are built bitwise so any DATA_W >= 4 works.
    always_comb begin
        for (int i = 0; i < DATA_W; i++) begin
            w_ldi[i]    = (i < 8) ? w_imm8[i[2:0]] : 1'b0;
            w_imm_sx[i] = (i < 6) ? w_imm8[i[2:0]] : w_imm8[5];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_res        = '0;
        w_c          = 1'b0;
        w_v          = 1'b0;
        w_writes     = 1'b0;
        w_sets_flags = 1'b0;
        w_jump       = 1'b0;
        w_stop       = 1'b0;
        w_illegal    = 1'b0;
        case (w_op)
            4'h0: ;
            4'h1: begin
                {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
                w_v          = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
            end
            4'h2: begin
                {w_c, w_res} = {1'b0, w_a} - {1'b0, w_b};
                w_v          = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
            end
            4'h3: begin w_res = w_a & w_b; w_writes = 1'b1; w_sets_flags = 1'b1; end
            4'h4: begin w_res = w_a | w_b; w_writes = 1'b1; w_sets_flags = 1'b1; end
            4'h5: begin w_res = w_a ^ w_b; w_writes = 1'b1; w_sets_flags = 1'b1; end
            4'h6: begin
                w_res        = {w_a[MSB-1:0], 1'b0};
                w_c          = w_a[MSB];
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
            end
            4'h7: begin
                w_res        = {1'b0, w_a[MSB:1]};
                w_c          = w_a[0];
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
            end
            4'h8: begin w_res = w_ldi; w_writes = 1'b1; end
            4'h9: begin
                {w_c, w_res} = {1'b0, w_a} + {1'b0, w_imm_sx};
                w_v          = (w_a[MSB] == w_imm_sx[MSB]) && (w_res[MSB] != w_a[MSB]);
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
            end
            4'hA: w_jump = 1'b1;
            4'hB: w_jump = r_flags[3];
            4'hC: w_jump = !r_flags[3];
            4'hD: begin
`ifdef CPU_MUL_EN
                w_res        = w_a * w_b;
                w_writes     = 1'b1;
                w_sets_flags = 1'b1;
`else
                w_illegal    = 1'b1;
`endif
            end
            4'hE: w_illegal = 1'b1;
            default: w_stop = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flags_nxt = r_flags;
        w_err_nxt   = r_err;
        w_load_ir   = 1'b0;
        w_reg_we    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (imem_ack && run) begin
                    w_load_ir   = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (run) begin
                    if (w_illegal) begin
                        w_state_nxt = S_HALT;
                        w_err_nxt   = 1'b1;
                    end else if (w_stop) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_reg_we    = w_writes && (w_rd != 3'd0);
                        if (w_sets_flags)
                            w_flags_nxt = {(w_res == '0), w_res[MSB], w_c, w_v};
                        w_pc_nxt    = w_jump ? w_tgt : r_pc + PC_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_FETCH;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: the register file is reset too, because software may read any register before writing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
            r_ir    <= '0;
            for (int i = 0; i < 8; i++)
                r_regs[i] <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_flags <= w_flags_nxt;
            r_err   <= w_err_nxt;
            if (w_load_ir)
                r_ir <= imem_rdata;
            if (w_reg_we)
                r_regs[w_rd] <= w_res;
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign dbg_pc    = r_pc;
    assign halted    = (r_state == S_HALT);
    assign err       = r_err;
    assign flags     = r_flags;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs with random fetch
// handshakes, compared against an instruction-level arithmetic model.
module tb_cpu_core;

    localparam int DMOD = 256;   // 2^DATA_W for the main instance
    localparam int PMOD = 256;   // 2^PC_W for the main instance

    logic        clk = 1'b0;
    logic        rst_n, run, imem_ack, imem_req, halted, err;
    logic [15:0] imem_rdata;
    logic [7:0]  imem_addr, dbg_pc;
    logic [3:0]  flags;

    logic        run_b, ack_b, req_b, halted_b, err_b;
    logic [15:0] rdata_b;
    logic [3:0]  addr_b, dbg_pc_b, flags_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    int          m_regs [8];
    int          m_pc;
    logic [3:0]  m_flags;
    bit          m_halted, m_err;
    logic [15:0] prog [256];

    cpu_core #(.DATA_W(8), .PC_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .halted(halted), .err(err), .flags(flags), .dbg_pc(dbg_pc)
    );

    cpu_core #(.DATA_W(8), .PC_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run_b),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b), .imem_rdata(rdata_b),
        .halted(halted_b), .err(err_b), .flags(flags_b), .dbg_pc(dbg_pc_b)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int sgn(input int x);
        return (x >= DMOD / 2) ? x - DMOD : x;
    endfunction

    function automatic bit ovf(input int x);
        return (x < -(DMOD / 2)) || (x >= DMOD / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0; m_flags = 4'b0; m_halted = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        int op, rd, ra, rb, imm8, imm6s, a, b, full, res;
        bit wr, upd, c, v, jmp;
        op = int'(ins[15:12]); rd = int'(ins[11:9]); ra = int'(ins[8:6]); rb = int'(ins[5:3]);
        imm8 = int'(ins[7:0]);
        imm6s = int'(ins[5:0]);
        if (imm6s >= 32) imm6s -= 64;
        a = m_regs[ra]; b = m_regs[rb];
        wr = 0; upd = 0; c = 0; v = 0; jmp = 0; res = 0; full = 0;
        case (op)
            1: begin full = a + b; res = full % DMOD; c = full >= DMOD; v = ovf(sgn(a) + sgn(b)); wr = 1; upd = 1; end
            2: begin res = (a - b + DMOD) % DMOD; c = a < b; v = ovf(sgn(a) - sgn(b)); wr = 1; upd = 1; end
            3: begin res = a & b; wr = 1; upd = 1; end
            4: begin res = a | b; wr = 1; upd = 1; end
            5: begin res = a ^ b; wr = 1; upd = 1; end
            6: begin res = (2 * a) % DMOD; c = a >= DMOD / 2; wr = 1; upd = 1; end
            7: begin res = a / 2; c = (a % 2) == 1; wr = 1; upd = 1; end
            8: begin res = imm8 % DMOD; wr = 1; end
            9: begin
                full = a + ((imm6s + DMOD) % DMOD); res = full % DMOD;
                c = full >= DMOD; v = ovf(sgn(a) + imm6s); wr = 1; upd = 1;
            end
            10: jmp = 1;
            11: jmp = m_flags[3];
            12: jmp = !m_flags[3];
`ifdef CPU_MUL_EN
            13: begin res = (a * b) % DMOD; wr = 1; upd = 1; end
`else
            13: begin m_halted = 1; m_err = 1; end
`endif
            14: begin m_halted = 1; m_err = 1; end
            15: m_halted = 1;
            default: ;
        endcase
        if (m_halted) return;
        if (upd) m_flags = {res == 0, res >= DMOD / 2, c, v};
        if (wr && rd != 0) m_regs[rd] = res;
        m_pc = jmp ? imm8 % PMOD : (m_pc + 1) % PMOD;
    endtask

    task automatic check_state();
        check("pc", 32'(dbg_pc), 32'(m_pc));
        check("flags", 32'(flags), 32'(m_flags));
        check("halted", 32'(halted), 32'(m_halted));
        check("err", 32'(err), 32'(m_err));
        for (int i = 0; i < 8; i++)
            check($sformatf("reg_r%0d", i), 32'(dut_a.r_regs[i]), 32'(m_regs[i]));
    endtask

    // mode 0: ack at once; 1: random waits/run drops/EXEC freezes; 2: three-cycle wait with run toggled
    task automatic exec_instr(input logic [15:0] ins, input int mode);
        int waits, frz;
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(m_pc));
        waits = (mode == 1) ? $urandom_range(0, 3) : ((mode == 2) ? 3 : 0);
        for (int k = 0; k < waits; k++) begin
            if (mode == 2) begin
                run = (k == 0); imem_ack = (k == 1);
            end else begin
                run = 1'($urandom_range(0, 1));
                imem_ack = run ? 1'b0 : 1'($urandom_range(0, 1));
            end
            imem_rdata = 16'($urandom);
            tick();
            check("wait_addr", 32'(imem_addr), 32'(m_pc));
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_pc", 32'(dbg_pc), 32'(m_pc));
        end
        run = 1'b1; imem_ack = 1'b1; imem_rdata = ins;
        tick();
        imem_ack = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = 16'($urandom);
        check("exec_req", 32'(imem_req), 32'd0);
        frz = (mode == 1) ? $urandom_range(0, 2) : 0;
        for (int k = 0; k < frz; k++) begin
            run = 1'b0;
            tick();
            check("frz_pc", 32'(dbg_pc), 32'(m_pc));
            check("frz_req", 32'(imem_req), 32'd0);
        end
        run = 1'b1;
        tick();
        imem_ack = 1'b0;
        model_exec(ins);
        check_state();
    endtask

    task automatic post_halt();
        for (int k = 0; k < 3; k++) begin
            run = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h8E55;
            tick();
            check("hold_halted", 32'(halted), 32'd1);
            check("hold_req", 32'(imem_req), 32'd0);
            check("hold_pc", 32'(dbg_pc), 32'(m_pc));
            check("hold_err", 32'(err), 32'(m_err));
        end
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        logic [31:0] any_reg;
        #2 rst_n = 1'b0;
        #1;
        any_reg = '0;
        for (int i = 0; i < 8; i++) any_reg |= 32'(dut_a.r_regs[i]);
        check("rst_pc", 32'(dbg_pc), 32'd0);
        check("rst_regs", any_reg, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_pc_b", 32'(dbg_pc_b), 32'd0);
        run = 1'b0; imem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    task automatic run_prog(input int mode, input int max_instr);
        for (int n = 0; n < max_instr && !m_halted; n++)
            exec_instr(prog[m_pc], mode);
    endtask

    initial begin
        rst_n = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        run_b = 1'b0; ack_b = 1'b0; rdata_b = '0;
        model_reset();
        tick(); tick();

        // Basic program, ack every cycle: halts after 8 cycles
        clear_prog();
        prog[0] = 16'h8205; prog[1] = 16'h8403; prog[2] = 16'h1650; prog[3] = 16'hF000;
        do_reset();
        cyc = 0;
        run_prog(0, 10);
        check("t1_cycles", 32'(cyc), 32'd8);
        check("t1_r3", 32'(dut_a.r_regs[3]), 32'h08);
        check("t1_flags", 32'(flags), 32'h0);
        check("t1_dbg_pc", 32'(dbg_pc), 32'd3);
        check("t1_halted", 32'(halted), 32'd1);
        post_halt();

        // Signed overflow on ADD, borrow on SUB
        clear_prog();
        prog[0] = 16'h827F; prog[1] = 16'h8401; prog[2] = 16'h1650; prog[3] = 16'h2888; prog[4] = 16'hF000;
        do_reset();
        for (int i = 0; i < 3; i++) exec_instr(prog[m_pc], 1);
        check("t2_r3", 32'(dut_a.r_regs[3]), 32'h80);
        check("t2_add_flags", 32'(flags), 32'b0101);
        exec_instr(prog[m_pc], 1);
        check("t2_r4", 32'(dut_a.r_regs[4]), 32'h82);
        check("t2_sub_flags", 32'(flags), 32'b0110);
        run_prog(1, 4);
        post_halt();

        // ADDI -1, branches, r0 write discarded
        clear_prog();
        prog[0] = 16'h8200; prog[1] = 16'h927F; prog[2] = 16'hB010; prog[3] = 16'h8009;
        prog[4] = 16'hC010; prog[16] = 16'h1A00; prog[17] = 16'hF000;
        do_reset();
        exec_instr(prog[m_pc], 0); exec_instr(prog[m_pc], 0);
        check("t3_r1", 32'(dut_a.r_regs[1]), 32'hFF);
        check("t3_addi_flags", 32'(flags), 32'b0100);
        exec_instr(prog[m_pc], 0);
        check("t3_beqz_not_taken", 32'(dbg_pc), 32'd3);
        exec_instr(prog[m_pc], 0);
        check("t3_r0", 32'(dut_a.r_regs[0]), 32'd0);
        exec_instr(prog[m_pc], 0);
        check("t3_bnez_taken", 32'(dbg_pc), 32'h10);
        run_prog(0, 4);
        check("t3_r5", 32'(dut_a.r_regs[5]), 32'd0);
        check("t3_flags", 32'(flags), 32'b1000);
        check("t3_halt_pc", 32'(dbg_pc), 32'h11);

        // Delayed ack with run dropped mid-wait
        clear_prog();
        prog[0] = 16'h825A; prog[1] = 16'hF000;
        do_reset();
        exec_instr(prog[0], 2);
        check("t4_r1", 32'(dut_a.r_regs[1]), 32'h5A);
        run_prog(2, 4);

        // Opcode D: MUL when enabled, illegal otherwise
        clear_prog();
        prog[0] = 16'h8210; prog[1] = 16'h8411; prog[2] = 16'hD650; prog[3] = 16'hE000; prog[4] = 16'hF000;
        do_reset();
        run_prog(0, 8);
`ifdef CPU_MUL_EN
        check("t5_mul_r3", 32'(dut_a.r_regs[3]), 32'h10);
        check("t5_mul_flags", 32'(flags), 32'b0000);
        check("t5_halt_pc", 32'(dbg_pc), 32'd3);
`else
        check("t5_halt_pc", 32'(dbg_pc), 32'd2);
`endif
        check("t5_err", 32'(err), 32'd1);
        check("t5_req", 32'(imem_req), 32'd0);
        post_halt();

        // Opcode E alone
        clear_prog();
        prog[0] = 16'hE123;
        do_reset();
        run_prog(0, 2);
        check("t6_halted", 32'(halted), 32'd1);
        check("t6_err", 32'(err), 32'd1);
        check("t6_pc", 32'(dbg_pc), 32'd0);

        // Reset mid-FETCH, then mid-EXEC
        clear_prog();
        prog[0] = 16'h8233; prog[1] = 16'h8444;
        do_reset();
        exec_instr(prog[0], 0);
        check("t7_r1", 32'(dut_a.r_regs[1]), 32'h33);
        do_reset();
        exec_instr(prog[0], 0);
        run = 1'b1; imem_ack = 1'b1; imem_rdata = prog[1];
        tick();
        imem_ack = 1'b0;
        do_reset();
        check("t7_r2_after_rst", 32'(dut_a.r_regs[2]), 32'd0);

        // PC_W=4 instance: JMP 0x1F lands on 0xF, then wraps to 0
        run_b = 1'b1; ack_b = 1'b1; rdata_b = 16'hA01F;
        check("b_addr0", 32'(addr_b), 32'd0);
        tick();
        check("b_exec_req", 32'(req_b), 32'd0);
        tick();
        check("b_jmp_addr", 32'(addr_b), 32'hF);
        check("b_jmp_pc", 32'(dbg_pc_b), 32'hF);
        rdata_b = 16'h0000;
        tick(); tick();
        check("b_wrap_addr", 32'(addr_b), 32'd0);
        check("b_flags", 32'(flags_b), 32'd0);
        check("b_halted", 32'(halted_b), 32'd0);
        check("b_err", 32'(err_b), 32'd0);
        run_b = 1'b0; ack_b = 1'b0;

        // Random programs with random handshakes
        for (int p = 0; p < 25; p++) begin
            for (int a = 0; a < 256; a++) begin
                int r;
                logic [3:0] op;
                r = $urandom_range(0, 99);
                if (r < 4)      op = 4'hF;
                else if (r < 6) op = 4'hE;
                else if (r < 9) op = 4'hD;
                else            op = 4'($urandom_range(0, 12));
                prog[a] = {op, 12'($urandom)};
            end
            do_reset();
            run_prog(1, 60);
            if (m_halted) post_halt();
        end
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
